// File: rtl/ram_sp_be_param_if.sv
// Client-side bus of the parametrised single-port byte-enable RAM.
// The master modport is the client; the slave modport is the RAM itself.
interface ram_sp_be_param_if #(
  parameter int ADR_WD = 8,
  parameter int DAT_WD = 512,
  parameter int COL_WD = 8
);
  localparam int COL_NUM = DAT_WD / COL_WD;

  logic               init_req_i;
  logic               init_busy_o;
  logic [ADR_WD-1:0]  adr_i;
  logic [COL_NUM-1:0] wr_ena_i;
  logic [DAT_WD-1:0]  wr_dat_i;
  logic               rd_ena_i;
  logic [DAT_WD-1:0]  rd_dat_o;
  logic               rd_val_o;

  modport master (
    output init_req_i,
    output adr_i,
    output wr_ena_i,
    output wr_dat_i,
    output rd_ena_i,
    input  init_busy_o,
    input  rd_dat_o,
    input  rd_val_o
  );

  modport slave (
    input  init_req_i,
    input  adr_i,
    input  wr_ena_i,
    input  wr_dat_i,
    input  rd_ena_i,
    output init_busy_o,
    output rd_dat_o,
    output rd_val_o
  );
endinterface

// File: rtl/ram_sp_be_param.sv
// Parametrised single-port RAM with per-column write enables, a 1- or 2-cycle
// registered read path with a valid strobe, and a zero-fill sequencer that
// clears every word after reset or on request before clients are served.
// Read-first on a same-cycle read/write. RD_LAT values other than 2 behave as 1.
module ram_sp_be_param #(
  parameter int ADR_WD = 8,
  parameter int DAT_WD = 512,
  parameter int COL_WD = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  ram_sp_be_param_if.slave  bus
);
  localparam int DEPTH   = 1 << ADR_WD;
  localparam int COL_NUM = DAT_WD / COL_WD;

  typedef enum logic {
    ST_INIT,
    ST_IDLE
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADR_WD-1:0] cnt_q;
  logic [ADR_WD-1:0] cnt_d;

  logic [DAT_WD-1:0] mem [DEPTH];

  logic              is_idle;
  logic              rd_acc;
  logic [DAT_WD-1:0] s1_dat_q;
  logic              s1_val_q;

  assign is_idle         = (state_q == ST_IDLE);
  assign rd_acc          = is_idle && bus.rd_ena_i;
  assign bus.init_busy_o = (state_q == ST_INIT);

  // Sequencer state and zero-fill address; reset restarts the fill from word 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Fill walks every address once and stops on the all-ones address; a request
  // in IDLE restarts it, while a request during the fill is ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == '1) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADR_WD'(1);
        end
      end
      ST_IDLE: begin
        if (bus.init_req_i) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Array write: zero a whole word during the fill, otherwise merge enabled columns.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem[cnt_q] <= '0;
    end else begin
      for (int k = 0; k < COL_NUM; k++) begin
        if (bus.wr_ena_i[k]) begin
          mem[bus.adr_i][k*COL_WD +: COL_WD] <= bus.wr_dat_i[k*COL_WD +: COL_WD];
        end
      end
    end
  end

  // First read stage samples the array before this edge's write lands (read-first)
  // and keeps its data when no read is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_dat_q <= '0;
      s1_val_q <= 1'b0;
    end else begin
      s1_val_q <= rd_acc;
      if (rd_acc) begin
        s1_dat_q <= mem[bus.adr_i];
      end
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [DAT_WD-1:0] out_dat_q;
      logic              out_val_q;

      // Extra output stage; data only moves when a result arrives so the port holds.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_dat_q <= '0;
          out_val_q <= 1'b0;
        end else begin
          out_val_q <= s1_val_q;
          if (s1_val_q) begin
            out_dat_q <= s1_dat_q;
          end
        end
      end

      assign bus.rd_dat_o = out_dat_q;
      assign bus.rd_val_o = out_val_q;
    end else begin : g_lat1
      assign bus.rd_dat_o = s1_dat_q;
      assign bus.rd_val_o = s1_val_q;
    end
  endgenerate
endmodule

// File: doc/ram_sp_be_param.md
Name: ram_sp_be_param

Overview:
- Parametrised single-port RAM with column byte-enables. Successor to the fixed-size single-port byte-enable RAM wrappers used by the encoder's line and CTU buffers.
- Adds configurable depth, width and column granularity.
- Adds a selectable 1- or 2-cycle read latency with a read-valid strobe.
- Adds a built-in zero-initialisation sequencer, so clients never read stale contents after reset or on a frame restart.

Parameters:
- ADR_WD, 8, address width; DEPTH = 2^ADR_WD words.
- DAT_WD, 512, data word width in bits.
- COL_WD, 8, bits per write-enable column; DAT_WD must be a multiple of COL_WD; COL_NUM = DAT_WD/COL_WD.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-high.
- init_req_i  input  1  pulse; restart the zero-fill sequence (honoured only in IDLE).
- init_busy_o  output  1  high while the zero-fill is running; client accesses are ignored while high.
- adr_i  input  ADR_WD  shared read/write address.
- wr_ena_i  input  COL_NUM  per-column write enable; bit k covers wr_dat_i[k*COL_WD +: COL_WD].
- wr_dat_i  input  DAT_WD  write data.
- rd_ena_i  input  1  read request.
- rd_dat_o  output  DAT_WD  read data.
- rd_val_o  output  1  one-cycle strobe; rd_dat_o is valid this cycle.

Behaviour:
- Reset values:
  - rd_dat_o = 0, rd_val_o = 0, init_busy_o = 1.
  - FSM = INIT, init counter = 0.
  - Memory array is not reset.
- FSM states:
  - INIT: each cycle, write all-zero (all columns) to address cnt; cnt increments. When cnt = DEPTH-1 is written, go to IDLE next cycle and drop init_busy_o. INIT therefore lasts exactly DEPTH cycles after rst deasserts.
  - IDLE: init_busy_o = 0, client accesses are served. init_req_i = 1 → INIT with cnt = 0; init_busy_o goes high the next cycle. The request-cycle access itself is still served.
- Client accesses while INIT:
  - wr_ena_i and rd_ena_i are ignored: no write, no rd_val_o.
  - init_req_i in INIT is ignored; the sequence does not restart.
- Write (IDLE):
  - For each k with wr_ena_i[k] = 1, column k of mem[adr_i] takes the wr_dat_i column at the clock edge.
  - Other columns are unchanged. wr_ena_i = 0 means no write.
- Read (IDLE), rd_ena_i = 1:
  - RD_LAT = 1: rd_dat_o = mem[adr_i] and rd_val_o = 1 on the following cycle.
  - RD_LAT = 2: one extra output register stage; data and strobe appear 2 cycles after the request.
  - Back-to-back reads are fully pipelined: one result per cycle, in order.
- rd_dat_o holds its last value when no result is delivered. rd_val_o is 0 in those cycles.
- Simultaneous read and write (same address, since the port is single): read-first. rd_dat_o returns the pre-write contents; the new data is visible to the next read.
- Reads in flight when init_req_i is accepted still complete with their pre-init data and rd_val_o.
- Reset mid-operation:
  - Asserting rst clears the pipeline immediately: rd_val_o = 0, rd_dat_o = 0.
  - FSM returns to INIT; any partially zeroed memory is fully re-zeroed after rst deasserts.
- Width rules:
  - The init counter is ADR_WD bits wide; the terminal condition is a compare with all-ones, with no wrap past DEPTH-1.
  - Address beyond DEPTH is impossible by construction.

Test Plan:
- Reset, ADR_WD=4 (DEPTH=16): release rst, count busy cycles → init_busy_o high exactly 16 cycles after rst deasserts. Then read all 16 addresses → every rd_dat_o = 0, one rd_val_o per read.
- Column write, DAT_WD=32, COL_WD=8: write 0xAABBCCDD to adr 3 with wr_ena=4'b1111, then 0x11223344 with wr_ena=4'b0101, then read adr 3 → 0xAA22CC44, RD_LAT cycles after the request.
- Read-first collision: mem[5]=0x0 ; same cycle rd_ena=1, wr_ena=all, wr_dat=0xDEADBEEF at adr 5 → read returns 0x00000000; next read of adr 5 → 0xDEADBEEF.
- Latency/pipelining, RD_LAT=2: reads to adr 0,1,2 on consecutive cycles after writing 1,2,3 → rd_val_o high on cycles t+2, t+3, t+4 with data 1,2,3; rd_val_o low elsewhere.
- init_req_i after writes: write 0x55 to adr 7, pulse init_req_i; writes and reads during busy are ignored with no rd_val_o. After DEPTH busy cycles, read adr 7 → 0.
- Reset mid-init: assert rst at init cycle 5, release → busy runs a full DEPTH cycles again; rd_val_o stays 0 throughout.
